// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer: eviction buffer between the L2 pmem port and memory.
// Buffers dirty lines, lets misses go first, drains when idle, forwards hits.
// Ports:
//   clk, rst                        clock, sync active-high reset
//   l2_address/l2_rdata/l2_wdata    L2-side line request and data
//   l2_read/l2_write/l2_resp        L2-side handshake (held until resp)
//   pmem_address/pmem_rdata/pmem_wdata  memory-side line request and data
//   pmem_read/pmem_write/pmem_resp  memory-side handshake
//   buf_count                       number of buffered lines
module l2_writeback_buffer #(
    parameter int DEPTH    = 4,
    parameter int s_offset = 5,
    parameter int s_line   = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                l2_address,
    output logic [s_line-1:0]          l2_rdata,
    input  logic [s_line-1:0]          l2_wdata,
    input  logic                       l2_read,
    input  logic                       l2_write,
    output logic                       l2_resp,
    output logic [31:0]                pmem_address,
    input  logic [s_line-1:0]          pmem_rdata,
    output logic [s_line-1:0]          pmem_wdata,
    output logic                       pmem_read,
    output logic                       pmem_write,
    input  logic                       pmem_resp,
    output logic [$clog2(DEPTH+1)-1:0] buf_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int TAG_W = 32 - s_offset;

    typedef enum logic [1:0] {IDLE, READ_MEM, DRAIN, RESP} state_t;

    state_t                         state_q, state_d;
    logic [PTR_W-1:0]               head_q, head_d;
    logic [PTR_W-1:0]               tail_q, tail_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic [DEPTH-1:0]               valid_q, valid_d;
    logic [DEPTH-1:0][TAG_W-1:0]    tag_q, tag_d;
    logic [DEPTH-1:0][s_line-1:0]   line_q, line_d;
    logic [s_line-1:0]              rdata_q, rdata_d;
    logic                           resp_q, resp_d;
    logic                           pread_q, pread_d;
    logic                           pwrite_q, pwrite_d;
    logic [31:0]                    paddr_q, paddr_d;
    logic [s_line-1:0]              pwdata_q, pwdata_d;

    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic [PTR_W-1:0] hit_idx;
    logic             unused_offset;

    assign req_tag       = l2_address[31:s_offset];
    assign unused_offset = ^l2_address[s_offset-1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Tags are unique, so at most one entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        line_d   = line_q;
        rdata_d  = rdata_q;
        resp_d   = 1'b0;
        pread_d  = pread_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;

        unique case (state_q)
            IDLE: begin
                if (l2_read) begin
                    if (hit) begin
                        rdata_d = line_q[hit_idx];
                        resp_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        pread_d = 1'b1;
                        paddr_d = {req_tag, {s_offset{1'b0}}};
                        state_d = READ_MEM;
                    end
                end else if (l2_write && hit) begin
                    line_d[hit_idx] = l2_wdata;
                    resp_d          = 1'b1;
                    state_d         = RESP;
                end else if (l2_write && (count_q != CNT_W'(DEPTH))) begin
                    valid_d[tail_q] = 1'b1;
                    tag_d[tail_q]   = req_tag;
                    line_d[tail_q]  = l2_wdata;
                    tail_d          = ptr_inc(tail_q);
                    count_d         = count_q + 1'b1;
                    resp_d          = 1'b1;
                    state_d         = RESP;
                end else if (l2_write || (count_q != '0)) begin
                    // Full-buffer write stays pending; it is retried after the drain.
                    pwrite_d = 1'b1;
                    paddr_d  = {tag_q[head_q], {s_offset{1'b0}}};
                    pwdata_d = line_q[head_q];
                    state_d  = DRAIN;
                end
            end
            READ_MEM: begin
                if (pmem_resp) begin
                    pread_d = 1'b0;
                    rdata_d = pmem_rdata;
                    resp_d  = 1'b1;
                    state_d = RESP;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    pwrite_d        = 1'b0;
                    valid_d[head_q] = 1'b0;
                    head_d          = ptr_inc(head_q);
                    count_d         = count_q - 1'b1;
                    state_d         = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            tag_q    <= '0;
            line_q   <= '0;
            rdata_q  <= '0;
            resp_q   <= 1'b0;
            pread_q  <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            line_q   <= line_d;
            rdata_q  <= rdata_d;
            resp_q   <= resp_d;
            pread_q  <= pread_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
        end
    end

    assign l2_rdata     = rdata_q;
    assign l2_resp      = resp_q;
    assign pmem_address = paddr_q;
    assign pmem_wdata   = pwdata_q;
    assign pmem_read    = pread_q;
    assign pmem_write   = pwrite_q;
    assign buf_count    = count_q;

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// tb_l2_writeback_buffer: directed bench for l2_writeback_buffer.
// Memory model with programmable latency logs every line write.
module tb_l2_writeback_buffer;

    logic         clk;
    logic         rst;
    logic [31:0]  l2_address;
    logic [255:0] l2_rdata;
    logic [255:0] l2_wdata;
    logic         l2_read;
    logic         l2_write;
    logic         l2_resp;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata;
    logic [255:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;
    logic         pmem_resp;
    logic [2:0]   buf_count;

    l2_writeback_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .l2_address   (l2_address),
        .l2_rdata     (l2_rdata),
        .l2_wdata     (l2_wdata),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_resp      (l2_resp),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_wdata   (pmem_wdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_resp    (pmem_resp),
        .buf_count    (buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int mem_lat = 3;
    int busy    = 0;
    int cyc     = 0;
    int rd_cnt  = 0;
    int rd_rise_cyc = 0;
    int wr_cyc  = 0;
    logic prev_rd    = 1'b0;
    logic both_high  = 1'b0;
    logic [31:0]  wr_addr_q[$];
    logic [255:0] wr_data_q[$];

    function automatic logic [255:0] mk(input logic [31:0] x);
        return {8{x}};
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        return {8{a ^ 32'hA5A5_0000}};
    endfunction

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: answers after mem_lat observed busy cycles.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pmem_read && pmem_write) both_high = 1'b1;
            if (pmem_read && !prev_rd) begin
                rd_cnt++;
                rd_rise_cyc = cyc;
            end
            prev_rd = pmem_read;
            if (rst || pmem_resp) begin
                pmem_resp = 1'b0;
                busy      = 0;
            end else if (pmem_read || pmem_write) begin
                busy++;
                if (busy >= mem_lat) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        wr_addr_q.push_back(pmem_address);
                        wr_data_q.push_back(pmem_wdata);
                        wr_cyc = cyc;
                    end else begin
                        pmem_rdata = mem_line(pmem_address);
                    end
                end
            end else begin
                busy = 0;
            end
        end
    end

    // Issue one L2 request; returns cycles until l2_resp and the read data.
    task automatic l2_req(input logic wr, input logic [31:0] addr,
                          input logic [255:0] data, output int lat,
                          output logic [255:0] rd);
        l2_address = addr;
        l2_wdata   = data;
        l2_write   = wr;
        l2_read    = !wr;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!l2_resp && lat < 300);
        rd       = l2_rdata;
        l2_read  = 1'b0;
        l2_write = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!(buf_count == 0 && !pmem_write && !pmem_read && !pmem_resp)
                   && k < 400);
        check(tag, 256'(k < 400), 256'(1));
    endtask

    int           lat;
    logic [255:0] rd;
    int           base;
    int           rbase;
    logic [31:0]  t4_addr[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        l2_address = '0;
        l2_wdata   = '0;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp",   256'(l2_resp),    256'(0));
        check("rst_pread",  256'(pmem_read),  256'(0));
        check("rst_pwrite", 256'(pmem_write), 256'(0));
        check("rst_count",  256'(buf_count),  256'(0));
        check("rst_rdata",  l2_rdata,         256'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // T1: single write, later drained to memory.
        base = wr_addr_q.size();
        l2_req(1'b1, 32'h0000_1040, mk(32'h1111_0001), lat, rd);
        check("t1_lat",    256'(lat),        256'(1));
        check("t1_count",  256'(buf_count),  256'(1));
        check("t1_nowr",   256'(pmem_write), 256'(0));
        wait_idle("t1_idle");
        check("t1_nwr",    256'(wr_addr_q.size()), 256'(base + 1));
        check("t1_addr",   256'(wr_addr_q[base]),  256'(32'h0000_1040));
        check("t1_data",   wr_data_q[base],        mk(32'h1111_0001));

        // T2: read hit forwarded from the buffer.
        rbase = rd_cnt;
        l2_req(1'b1, 32'h0000_1040, mk(32'h2222_0002), lat, rd);
        check("t2_wlat",   256'(lat), 256'(1));
        l2_req(1'b0, 32'h0000_1044, '0, lat, rd);
        check("t2_rlat",   256'(lat), 256'(2));
        check("t2_rdata",  rd,        mk(32'h2222_0002));
        check("t2_nopr",   256'(rd_cnt), 256'(rbase));
        wait_idle("t2_idle");

        // T3: coalescing writes to the same line.
        base = wr_addr_q.size();
        l2_req(1'b1, 32'h0000_1040, mk(32'h3333_00D1), lat, rd);
        l2_req(1'b1, 32'h0000_1040, mk(32'h3333_00D2), lat, rd);
        check("t3_lat",    256'(lat),       256'(2));
        check("t3_count",  256'(buf_count), 256'(1));
        wait_idle("t3_idle");
        check("t3_nwr",    256'(wr_addr_q.size()), 256'(base + 1));
        check("t3_data",   wr_data_q[base],        mk(32'h3333_00D2));

        // T4: full buffer forces a drain before the fifth write.
        mem_lat = 10;
        base = wr_addr_q.size();
        t4_addr = '{32'h0000_2000, 32'h0000_2020, 32'h0000_2040,
                    32'h0000_2060, 32'h0000_3000};
        for (int i = 0; i < 4; i++) begin
            l2_req(1'b1, t4_addr[i], mk(32'h4444_0000 + i), lat, rd);
        end
        check("t4_full",   256'(buf_count), 256'(4));
        l2_req(1'b1, t4_addr[4], mk(32'h4444_00BB), lat, rd);
        check("t4_lat",    256'(lat),       256'(13));
        check("t4_count",  256'(buf_count), 256'(4));
        wait_idle("t4_idle");
        check("t4_nwr",    256'(wr_addr_q.size()), 256'(base + 5));
        for (int i = 0; i < 5; i++) begin
            if (base + i < wr_addr_q.size())
                check($sformatf("t4_order%0d", i),
                      256'(wr_addr_q[base+i]), 256'(t4_addr[i]));
        end
        if (base + 4 < wr_data_q.size()) begin
            check("t4_d0", wr_data_q[base],   mk(32'h4444_0000));
            check("t4_d4", wr_data_q[base+4], mk(32'h4444_00BB));
        end

        // T5: read miss issued while a drain is in flight.
        rbase = rd_cnt;
        l2_req(1'b1, 32'h0000_4000, mk(32'h5555_0005), lat, rd);
        repeat (3) @(posedge clk);
        #1;
        check("t5_drain",  256'(pmem_write), 256'(1));
        l2_req(1'b0, 32'h8000_0000, '0, lat, rd);
        check("t5_rdata",  rd,               mem_line(32'h8000_0000));
        check("t5_nrd",    256'(rd_cnt),     256'(rbase + 1));
        check("t5_order",  256'(rd_rise_cyc > wr_cyc), 256'(1));
        wait_idle("t5_idle");

        // T6: reset in the middle of a drain discards the buffer.
        mem_lat = 20;
        base = wr_addr_q.size();
        l2_req(1'b1, 32'h0000_5000, mk(32'h6666_0000), lat, rd);
        l2_req(1'b1, 32'h0000_5020, mk(32'h6666_0001), lat, rd);
        l2_req(1'b1, 32'h0000_5040, mk(32'h6666_0002), lat, rd);
        repeat (3) @(posedge clk);
        #1;
        check("t6_drain",  256'(pmem_write), 256'(1));
        check("t6_cnt3",   256'(buf_count),  256'(3));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_pwrite", 256'(pmem_write), 256'(0));
        check("t6_count",  256'(buf_count),  256'(0));
        check("t6_resp",   256'(l2_resp),    256'(0));
        rst = 1'b0;
        mem_lat = 2;
        @(posedge clk);
        #1;
        rbase = rd_cnt;
        l2_req(1'b0, 32'h0000_5000, '0, lat, rd);
        check("t6_rlat",   256'(lat),        256'(3));
        check("t6_rdata",  rd,               mem_line(32'h0000_5000));
        check("t6_nrd",    256'(rd_cnt),     256'(rbase + 1));
        check("t6_nwr",    256'(wr_addr_q.size()), 256'(base));

        check("never_both", 256'(both_high), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
